// File: rtl/ili9341_spi_responder_pkg.sv
// ili9341_spi_responder_pkg
//   Shared ILI9341 definitions: command opcodes understood by the responder,
//   the RGB565 pixel colour layout, and the address-window range check.
package ili9341_spi_responder_pkg;

  // Command opcodes (sent with data_commandb = 0).
  typedef enum logic [7:0] {
    NOP   = 8'h00,
    CASET = 8'h2A,
    PASET = 8'h2B,
    RAMWR = 8'h2C
  } ILI9341_register_t;

  // RGB565. The first RAMWR byte of a pixel carries red and the top of green.
  typedef struct packed {
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
  } ILI9341_color_t;

  // A CASET/PASET window is accepted only when it is non-empty and its end
  // coordinate lies on the panel.
  function automatic logic window_ok(input logic [15:0] start,
                                     input logic [15:0] stop,
                                     input logic [15:0] limit);
    return (start <= stop) && (stop < limit);
  endfunction

endpackage

// File: rtl/ili9341_spi_responder_deserializer.sv
// spi_peripheral_deserializer
//   Mode-0 SPI receive front end for a peripheral clocked by the system clock.
//   All SPI inputs are oversampled through SYNC_STAGES-deep synchronizers; a
//   rising edge of the synchronized SPI clock shifts in one MOSI bit (MSB
//   first). The eighth bit raises byte_strobe for one clk together with the
//   assembled byte and the data/command flag sampled alongside that bit.
//   Deasserting chip select discards any partial byte.
//
//   Ports
//     clk, rstb      system clock, asynchronous active-low reset
//     spi_csb        chip select, active low
//     spi_clk        SPI clock (idle low, sample on rising edge)
//     spi_mosi       serial data, MSB first
//     spi_dc         side-band flag sampled with the 8th bit
//     byte_strobe    one-cycle pulse when a byte is complete
//     rx_byte        completed byte (valid with byte_strobe)
//     byte_dc        spi_dc captured with the 8th bit
module spi_peripheral_deserializer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       spi_csb,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  output logic       byte_strobe,
  output logic [7:0] rx_byte,
  output logic       byte_dc
);

  logic [SYNC_STAGES-1:0] csb_sr;
  logic [SYNC_STAGES-1:0] sclk_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic [SYNC_STAGES-1:0] dc_sr;

  logic       csb_s;
  logic       sclk_s;
  logic       mosi_s;
  logic       dc_s;
  logic       sclk_prev;
  logic       csb_prev;
  logic       sclk_rise;
  logic       shift_en;
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;

  // Synchronizers: bit 0 takes the raw pin, the top bit is the clean sample.
  // Chip select resets to its inactive (high) level.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      csb_sr  <= '1;
      sclk_sr <= '0;
      mosi_sr <= '0;
      dc_sr   <= '0;
    end else begin
      csb_sr  <= (csb_sr  << 1) | SYNC_STAGES'(spi_csb);
      sclk_sr <= (sclk_sr << 1) | SYNC_STAGES'(spi_clk);
      mosi_sr <= (mosi_sr << 1) | SYNC_STAGES'(spi_mosi);
      dc_sr   <= (dc_sr   << 1) | SYNC_STAGES'(spi_dc);
    end
  end

  assign csb_s     = csb_sr[SYNC_STAGES-1];
  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign dc_s      = dc_sr[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  // An edge still counts when chip select rises in the very same sample, so a
  // master that releases csb right after its last clock edge loses nothing.
  assign shift_en  = sclk_rise & (~csb_s | ~csb_prev);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sclk_prev   <= 1'b0;
      csb_prev    <= 1'b1;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      byte_strobe <= 1'b0;
      rx_byte     <= '0;
      byte_dc     <= 1'b0;
    end else begin
      sclk_prev   <= sclk_s;
      csb_prev    <= csb_s;
      byte_strobe <= 1'b0;
      if (shift_en) begin
        if (bit_cnt == 3'd7) begin
          byte_strobe <= 1'b1;
          rx_byte     <= {shift_reg, mosi_s};
          byte_dc     <= dc_s;
          bit_cnt     <= '0;
        end else begin
          shift_reg <= {shift_reg[5:0], mosi_s};
          bit_cnt   <= bit_cnt + 3'd1;
        end
      end else if (csb_s) begin
        bit_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ili9341_spi_responder.sv
// ili9341_spi_responder
//   Receive-side model of the ILI9341 8-bit SPI write link. Bytes from the
//   deserializer are decoded into commands; CASET/PASET update the address
//   window and RAMWR data becomes addressed RGB565 pixel writes that stream
//   through the window in raster order, wrapping at its end.
//
//   Ports
//     clk, rstb        system clock, asynchronous active-low reset
//     spi_csb          chip select, active low
//     spi_clk          SPI clock, mode 0
//     spi_mosi         serial data, MSB first
//     spi_miso         tied low (reads unsupported)
//     data_commandb    1 = data byte, 0 = command byte
//     cmd_valid/cmd    pulse and value of each received command byte
//     pixel_valid      pulse per completed pixel, with pixel_x/y/color
//     frame_done       pulses with the pixel written at (EC,EP)
//     protocol_error   pulse on an incomplete or out-of-range window command
//     dbg_state        current decoder state
//
//   Handshake: there is no back-pressure. Every output pulse is high for
//   exactly one clk, registered one clk after the internal byte strobe, and
//   its companion data outputs are valid in that same cycle and hold until
//   the next pulse of the same kind.
module ili9341_spi_responder
  import ili9341_spi_responder_pkg::*;
#(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              spi_csb,
  input  logic                              spi_clk,
  input  logic                              spi_mosi,
  output logic                              spi_miso,
  input  logic                              data_commandb,
  output logic                              cmd_valid,
  output logic [7:0]                        cmd,
  output logic                              pixel_valid,
  output logic [$clog2(DISPLAY_WIDTH)-1:0]  pixel_x,
  output logic [$clog2(DISPLAY_HEIGHT)-1:0] pixel_y,
  output ILI9341_color_t                    pixel_color,
  output logic                              frame_done,
  output logic                              protocol_error,
  output logic [2:0]                        dbg_state
);

  localparam int XW = $clog2(DISPLAY_WIDTH);
  localparam int YW = $clog2(DISPLAY_HEIGHT);
  localparam logic [15:0]   WIDTH_LIMIT  = 16'(DISPLAY_WIDTH);
  localparam logic [15:0]   HEIGHT_LIMIT = 16'(DISPLAY_HEIGHT);
  localparam logic [XW-1:0] X_LAST       = XW'(DISPLAY_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST       = YW'(DISPLAY_HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CASET    = 3'd1,
    S_PASET    = 3'd2,
    S_RAMWR_HI = 3'd3,
    S_RAMWR_LO = 3'd4,
    S_IGNORE   = 3'd5
  } state_t;

  logic       byte_strobe;
  logic [7:0] rx_byte;
  logic       byte_dc;

  spi_peripheral_deserializer #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_deser (
    .clk         (clk),
    .rstb        (rstb),
    .spi_csb     (spi_csb),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_dc      (data_commandb),
    .byte_strobe (byte_strobe),
    .rx_byte     (rx_byte),
    .byte_dc     (byte_dc)
  );

  // Registered state and its next-state copies.
  state_t         state, state_n;
  logic [XW-1:0]  sc, sc_n, ec, ec_n, cur_x, cur_x_n;
  logic [YW-1:0]  sp, sp_n, ep, ep_n, cur_y, cur_y_n;
  logic [1:0]     par_cnt, par_cnt_n;
  logic [15:0]    par_start, par_start_n;
  logic [7:0]     par_end_hi, par_end_hi_n;
  logic [7:0]     color_hi, color_hi_n;
  logic           cmd_valid_n, pixel_valid_n, frame_done_n, perr_n;
  logic [7:0]     cmd_n;
  logic [XW-1:0]  pixel_x_n;
  logic [YW-1:0]  pixel_y_n;
  ILI9341_color_t pixel_color_n;
  logic [15:0]    end_word;

  assign spi_miso  = 1'b0;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state          <= S_IDLE;
      sc             <= '0;
      ec             <= X_LAST;
      sp             <= '0;
      ep             <= Y_LAST;
      cur_x          <= '0;
      cur_y          <= '0;
      par_cnt        <= '0;
      par_start      <= '0;
      par_end_hi     <= '0;
      color_hi       <= '0;
      cmd_valid      <= 1'b0;
      cmd            <= '0;
      pixel_valid    <= 1'b0;
      pixel_x        <= '0;
      pixel_y        <= '0;
      pixel_color    <= '0;
      frame_done     <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state          <= state_n;
      sc             <= sc_n;
      ec             <= ec_n;
      sp             <= sp_n;
      ep             <= ep_n;
      cur_x          <= cur_x_n;
      cur_y          <= cur_y_n;
      par_cnt        <= par_cnt_n;
      par_start      <= par_start_n;
      par_end_hi     <= par_end_hi_n;
      color_hi       <= color_hi_n;
      cmd_valid      <= cmd_valid_n;
      cmd            <= cmd_n;
      pixel_valid    <= pixel_valid_n;
      pixel_x        <= pixel_x_n;
      pixel_y        <= pixel_y_n;
      pixel_color    <= pixel_color_n;
      frame_done     <= frame_done_n;
      protocol_error <= perr_n;
    end
  end

  always_comb begin
    state_n       = state;
    sc_n          = sc;
    ec_n          = ec;
    sp_n          = sp;
    ep_n          = ep;
    cur_x_n       = cur_x;
    cur_y_n       = cur_y;
    par_cnt_n     = par_cnt;
    par_start_n   = par_start;
    par_end_hi_n  = par_end_hi;
    color_hi_n    = color_hi;
    cmd_valid_n   = 1'b0;
    cmd_n         = cmd;
    pixel_valid_n = 1'b0;
    pixel_x_n     = pixel_x;
    pixel_y_n     = pixel_y;
    pixel_color_n = pixel_color;
    frame_done_n  = 1'b0;
    perr_n        = 1'b0;
    end_word      = {par_end_hi, rx_byte};

    if (byte_strobe) begin
      if (!byte_dc) begin
        cmd_valid_n = 1'b1;
        cmd_n       = rx_byte;
        par_cnt_n   = '0;
        // Still in a window state means fewer than four parameters arrived;
        // the old window is kept because nothing was committed yet.
        if (state == S_CASET || state == S_PASET) perr_n = 1'b1;
        case (rx_byte)
          CASET:   state_n = S_CASET;
          PASET:   state_n = S_PASET;
          RAMWR: begin
            state_n = S_RAMWR_HI;
            cur_x_n = sc;
            cur_y_n = sp;
          end
          NOP:     state_n = S_IDLE;
          default: state_n = S_IGNORE;
        endcase
      end else begin
        case (state)
          S_CASET, S_PASET: begin
            par_cnt_n = par_cnt + 2'd1;
            case (par_cnt)
              2'd0:    par_start_n[15:8] = rx_byte;
              2'd1:    par_start_n[7:0]  = rx_byte;
              2'd2:    par_end_hi_n      = rx_byte;
              default: begin
                state_n = S_IGNORE;
                if (state == S_CASET) begin
                  if (window_ok(par_start, end_word, WIDTH_LIMIT)) begin
                    sc_n = par_start[XW-1:0];
                    ec_n = end_word[XW-1:0];
                  end else begin
                    perr_n = 1'b1;
                  end
                end else begin
                  if (window_ok(par_start, end_word, HEIGHT_LIMIT)) begin
                    sp_n = par_start[YW-1:0];
                    ep_n = end_word[YW-1:0];
                  end else begin
                    perr_n = 1'b1;
                  end
                end
              end
            endcase
          end
          S_RAMWR_HI: begin
            color_hi_n = rx_byte;
            state_n    = S_RAMWR_LO;
          end
          S_RAMWR_LO: begin
            pixel_valid_n = 1'b1;
            pixel_x_n     = cur_x;
            pixel_y_n     = cur_y;
            pixel_color_n = ILI9341_color_t'({color_hi, rx_byte});
            frame_done_n  = (cur_x == ec) && (cur_y == ep);
            // Raster advance inside the window, wrapping to its origin.
            if (cur_x == ec) begin
              cur_x_n = sc;
              cur_y_n = (cur_y == ep) ? sp : cur_y + YW'(1);
            end else begin
              cur_x_n = cur_x + XW'(1);
            end
            state_n = S_RAMWR_HI;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ili9341_spi_responder.sv
module tb_ili9341_spi_responder;

  localparam int XW = 8;
  localparam int YW = 9;
  localparam int PW = 1 + XW + YW + 16;
  localparam int H  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstb = 1'b0;
  always #5 clk = ~clk;

  logic          spi_csb = 1'b1;
  logic          spi_clk = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          data_commandb = 1'b0;
  logic          spi_miso;
  logic          cmd_valid;
  logic [7:0]    cmd;
  logic          pixel_valid;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic [15:0]   pixel_color;
  logic          frame_done;
  logic          protocol_error;
  logic [2:0]    dbg_state;

  ili9341_spi_responder dut (
    .clk            (clk),
    .rstb           (rstb),
    .spi_csb        (spi_csb),
    .spi_clk        (spi_clk),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .data_commandb  (data_commandb),
    .cmd_valid      (cmd_valid),
    .cmd            (cmd),
    .pixel_valid    (pixel_valid),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .pixel_color    (pixel_color),
    .frame_done     (frame_done),
    .protocol_error (protocol_error),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  logic [7:0]    exp_cmd_q[$];
  int            exp_perr = 0;

  logic [PW-1:0] obs_pix[0:255];
  logic [7:0]    obs_cmd[0:255];
  int            obs_pix_n = 0;
  int            obs_cmd_n = 0;
  int            perr_n = 0;
  int            stray_fd = 0;
  int            rd_pix = 0;
  int            rd_cmd = 0;

  int compared = 0;
  int mismatched = 0;

  always @(negedge clk) begin
    if (pixel_valid) begin
      obs_pix[obs_pix_n % 256] = {frame_done, pixel_x, pixel_y, pixel_color};
      obs_pix_n++;
    end else if (frame_done) begin
      stray_fd++;
    end
    if (cmd_valid) begin
      obs_cmd[obs_cmd_n % 256] = cmd;
      obs_cmd_n++;
    end
    if (protocol_error) perr_n++;
  end

  function automatic logic [PW-1:0] pix(input int x, input int y,
                                        input logic [15:0] c, input logic fd);
    return {fd, XW'(x), YW'(y), c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag);
    logic [PW-1:0] e, o;
    logic [7:0] ec, oc;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk({tag, " pixel_count"}, 64'(obs_pix_n - rd_pix), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_pix < obs_pix_n) begin
        o = obs_pix[rd_pix % 256];
        rd_pix++;
      end else o = 'x;
      chk({tag, " pixel{fd,x,y,color}"}, 64'(o), 64'(e));
    end
    rd_pix = obs_pix_n;
    chk({tag, " cmd_count"}, 64'(obs_cmd_n - rd_cmd), 64'(exp_cmd_q.size()));
    while (exp_cmd_q.size() > 0) begin
      ec = exp_cmd_q.pop_front();
      if (rd_cmd < obs_cmd_n) begin
        oc = obs_cmd[rd_cmd % 256];
        rd_cmd++;
      end else oc = 'x;
      chk({tag, " cmd"}, 64'(oc), 64'(ec));
    end
    rd_cmd = obs_cmd_n;
    chk({tag, " protocol_error_count"}, 64'(perr_n), 64'(exp_perr));
    chk({tag, " stray_frame_done"}, 64'(stray_fd), 64'(0));
  endtask

  // ---------------- drivers ----------------
  task automatic cs_low();
    spi_csb = 1'b0;
    repeat (H) @(posedge clk);
  endtask

  task automatic cs_high();
    repeat (H) @(posedge clk);
    spi_csb = 1'b1;
    repeat (2 * H) @(posedge clk);
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    repeat (H) @(posedge clk);
    spi_clk = 1'b1;
    repeat (H) @(posedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    data_commandb = dc;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    repeat (H) @(posedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    send_byte(1'b0, c);
    exp_cmd_q.push_back(c);
  endtask

  task automatic send_params(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
    send_cmd(c);
    send_byte(1'b1, s[15:8]);
    send_byte(1'b1, s[7:0]);
    send_byte(1'b1, e[15:8]);
    send_byte(1'b1, e[7:0]);
  endtask

  task automatic send_pixel(input int x, input int y, input logic fd);
    logic [15:0] c;
    c = 16'($urandom_range(0, 65535));
    send_byte(1'b1, c[15:8]);
    send_byte(1'b1, c[7:0]);
    exp_q.push_back(pix(x, y, c, fd));
  endtask

  task automatic do_reset();
    spi_csb = 1'b1;
    spi_clk = 1'b0;
    @(negedge clk);
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset pulses{cmd_valid,pixel_valid,frame_done,protocol_error,miso}",
        64'({cmd_valid, pixel_valid, frame_done, protocol_error, spi_miso}), 64'(0));
    chk("reset cmd", 64'(cmd), 64'(0));
    chk("reset pixel{x,y,color}", 64'({pixel_x, pixel_y, pixel_color}), 64'(0));
    chk("reset state", 64'(dbg_state), 64'(0));
    rstb = 1'b1;
    repeat (4) @(posedge clk);

    // Default window: two pixels in raster order.
    cs_low();
    send_cmd(8'h2C);
    send_byte(1'b1, 8'hF8);
    send_byte(1'b1, 8'h00);
    exp_q.push_back(pix(0, 0, 16'hF800, 1'b0));
    send_byte(1'b1, 8'h07);
    send_byte(1'b1, 8'hE0);
    exp_q.push_back(pix(1, 0, 16'h07E0, 1'b0));
    cs_high();
    drain("ramwr_default");

    // 2x2 window with wrap; extra parameter byte after CASET is ignored;
    // streaming continues across a chip-select gap.
    cs_low();
    send_params(8'h2A, 16'd10, 16'd11);
    send_byte(1'b1, 8'hFF);
    send_params(8'h2B, 16'd5, 16'd6);
    send_cmd(8'h2C);
    send_pixel(10, 5, 1'b0);
    send_pixel(11, 5, 1'b0);
    cs_high();
    cs_low();
    send_pixel(10, 6, 1'b0);
    send_pixel(11, 6, 1'b1);
    send_pixel(10, 5, 1'b0);
    cs_high();
    drain("window_2x2");

    // Rejected windows keep the reset window.
    do_reset();
    cs_low();
    send_params(8'h2A, 16'd240, 16'd240);
    exp_perr++;
    send_params(8'h2B, 16'd0, 16'd320);
    exp_perr++;
    send_params(8'h2B, 16'd5, 16'd4);
    exp_perr++;
    send_cmd(8'h2C);
    send_pixel(0, 0, 1'b0);
    cs_high();
    drain("bad_window");

    // Truncated CASET then NOP; dangling HI byte at a new command is silent.
    cs_low();
    send_cmd(8'h2A);
    send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h01);
    send_cmd(8'h00);
    exp_perr++;
    send_cmd(8'h2C);
    send_pixel(0, 0, 1'b0);
    send_byte(1'b1, 8'h5A);
    send_cmd(8'h00);
    send_byte(1'b1, 8'h11);
    cs_high();
    drain("short_caset");

    // Partial byte discarded by chip-select release.
    cs_low();
    data_commandb = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    cs_high();
    cs_low();
    send_cmd(8'h2C);
    send_pixel(0, 0, 1'b0);
    cs_high();
    drain("partial_byte");

    // Window at the far panel corner; frame_done at (239,319).
    cs_low();
    send_params(8'h2A, 16'd238, 16'd239);
    send_params(8'h2B, 16'd318, 16'd319);
    send_cmd(8'h2C);
    send_pixel(238, 318, 1'b0);
    send_pixel(239, 318, 1'b0);
    send_pixel(238, 319, 1'b0);
    send_pixel(239, 319, 1'b1);
    send_pixel(238, 318, 1'b0);
    cs_high();
    drain("corner_window");

    // Reset in the middle of a pixel.
    cs_low();
    send_cmd(8'h2C);
    send_byte(1'b1, 8'h12);
    repeat (10) @(posedge clk);
    #3 rstb = 1'b0;
    #1;
    chk("async_reset pulses", 64'({cmd_valid, pixel_valid, frame_done, protocol_error}), 64'(0));
    chk("async_reset cmd", 64'(cmd), 64'(0));
    chk("async_reset pixel{x,y,color}", 64'({pixel_x, pixel_y, pixel_color}), 64'(0));
    chk("async_reset state", 64'(dbg_state), 64'(0));
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (4) @(posedge clk);
    send_byte(1'b1, 8'h34);
    send_byte(1'b1, 8'h56);
    cs_high();
    drain("reset_mid_pixel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
